// File: rtl/vga_plot_arbiter.sv
// Shares the VGA adapter write port between the screen, brick, paddle and ball drawers.
// Grants are bounded bursts gated by the current screen; the pixel output is registered.
module vga_plot_arbiter #(
  parameter int unsigned X_W       = 8,
  parameter int unsigned Y_W       = 7,
  parameter int unsigned C_W       = 3,
  parameter int unsigned MAX_BURST = 16
) (
  input  logic             clock,
  input  logic             reset_plot_arbiter,
  input  logic [1:0]       sel_screen,
  input  logic [3:0]       req,
  input  logic [4*X_W-1:0] x_in,
  input  logic [4*Y_W-1:0] y_in,
  input  logic [4*C_W-1:0] colour_in,
  output logic [3:0]       grant,
  output logic [X_W-1:0]   vga_x,
  output logic [Y_W-1:0]   vga_y,
  output logic [C_W-1:0]   vga_colour,
  output logic             vga_plot,
  output logic             busy
);

  typedef enum logic [0:0] {StIdle, StOwn} state_e;

  state_e         state_q, state_d;
  logic [3:0]     grant_q, grant_d;
  logic [7:0]     cnt_q, cnt_d;
  logic [1:0]     last_q, last_d;
  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;
  logic [C_W-1:0] colour_q, colour_d;
  logic           plot_q, plot_d;

  logic [3:0]     elig_mask;
  logic [3:0]     elig_req;
  logic [1:0]     own_idx;
  logic [1:0]     rr_win;
  logic           rr_found;
  logic [2:0]     rr_cand;
  logic [8:0]     cnt_inc;
  logic [X_W-1:0] own_x;
  logic [Y_W-1:0] own_y;
  logic [C_W-1:0] own_colour;

  always_comb begin
    unique case (sel_screen)
      2'd0, 2'd1: elig_mask = 4'b0001;
      2'd2:       elig_mask = 4'b1110;
      default:    elig_mask = 4'b0000;
    endcase
  end

  assign elig_req = req & elig_mask;
  assign cnt_inc  = {1'b0, cnt_q} + 9'd1;

  // Owner index and its pixel fields, decoded from the one-hot grant.
  always_comb begin
    own_idx    = '0;
    own_x      = '0;
    own_y      = '0;
    own_colour = '0;
    for (int i = 0; i < 4; i++) begin
      if (grant_q[i]) begin
        own_idx    = 2'(i);
        own_x      = x_in[i*X_W +: X_W];
        own_y      = y_in[i*Y_W +: Y_W];
        own_colour = colour_in[i*C_W +: C_W];
      end
    end
  end

  // Round-robin over requesters 1..3, starting after last_q and wrapping 3 -> 1.
  always_comb begin
    rr_win   = last_q;
    rr_found = 1'b0;
    rr_cand  = '0;
    for (int i = 1; i <= 3; i++) begin
      rr_cand = {1'b0, last_q} + 3'(i);
      if (rr_cand > 3'd3) rr_cand = rr_cand - 3'd3;
      if (!rr_found && elig_req[rr_cand[1:0]]) begin
        rr_found = 1'b1;
        rr_win   = rr_cand[1:0];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    x_d      = x_q;
    y_d      = y_q;
    colour_d = colour_q;
    plot_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        grant_d = 4'b0000;
        if (|elig_req) begin
          state_d = StOwn;
          cnt_d   = '0;
          if (sel_screen == 2'd2) begin
            grant_d = 4'b0001 << rr_win;
            last_d  = rr_win;
          end else begin
            grant_d = 4'b0001;
          end
        end
      end
      StOwn: begin
        if (req[own_idx] && elig_mask[own_idx]) begin
          x_d      = own_x;
          y_d      = own_y;
          colour_d = own_colour;
          plot_d   = 1'b1;
          cnt_d    = cnt_inc[7:0];
          if (cnt_inc == 9'(MAX_BURST)) begin
            grant_d = 4'b0000;
            state_d = StIdle;
          end
        end else begin
          // Release or preemption: drop the grant without taking a pixel.
          grant_d = 4'b0000;
          state_d = StIdle;
        end
      end
      default: begin
        grant_d = 4'b0000;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_plot_arbiter) begin
      state_q  <= StIdle;
      grant_q  <= 4'b0000;
      cnt_q    <= '0;
      last_q   <= 2'd3;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
      plot_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      x_q      <= x_d;
      y_q      <= y_d;
      colour_q <= colour_d;
      plot_q   <= plot_d;
    end
  end

  assign grant      = grant_q;
  assign busy       = |grant_q;
  assign vga_x      = x_q;
  assign vga_y      = y_q;
  assign vga_colour = colour_q;
  assign vga_plot   = plot_q;

endmodule
